ysyx_23060077_div_ctrl: RTL and testbench

YSYX_23060077_DIV_CTRL -- requirements
Module: ysyx_23060077_div_ctrl

---
 rtl/ysyx_23060077_div_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ysyx_23060077_div_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer in front of a multi-cycle divider; resolves
// divide-by-zero and signed overflow locally. Optional result reuse: YSYX_23060077_DIV_REUSE_EN.
module ysyx_23060077_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             div_valid,
  input  logic             div_ready,
  output logic             div_signed,
  output logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] divisor,
  output logic             div_flush,
  input  logic             div_out_valid,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_r;
  logic             select_rem_r;
  logic             req_signed_s;
  logic             req_rem_s;
  logic             special_s;
  logic [WIDTH-1:0] special_data_s;
  logic             hit_s;
  logic [WIDTH-1:0] hit_data_s;

  // Classify the incoming request and form the locally resolved result
  always_comb begin
    req_signed_s   = ~req_op[0];
    req_rem_s      = req_op[1];
    special_s      = 1'b0;
    special_data_s = ZERO;
    if (req_b == ZERO) begin
      special_s      = 1'b1;
      special_data_s = req_rem_s ? req_a : ALL_ONES;
    end else if (req_signed_s && (req_a == MIN_NEG) && (req_b == ALL_ONES)) begin
      special_s      = 1'b1;
      special_data_s = req_rem_s ? ZERO : req_a;
    end else begin
      special_s      = 1'b0;
      special_data_s = ZERO;
    end
  end

`ifdef YSYX_23060077_DIV_REUSE_EN
  logic             ent_valid_r;
  logic             ent_signed_r;
  logic [WIDTH-1:0] ent_a_r;
  logic [WIDTH-1:0] ent_b_r;
  logic [WIDTH-1:0] ent_q_r;
  logic [WIDTH-1:0] ent_r_r;

  // Record every divider completion that was not killed in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid_r  <= 1'b0;
      ent_signed_r <= 1'b0;
      ent_a_r      <= ZERO;
      ent_b_r      <= ZERO;
      ent_q_r      <= ZERO;
      ent_r_r      <= ZERO;
    end else if ((state_r == WAIT) && div_out_valid && !flush) begin
      ent_valid_r  <= 1'b1;
      ent_signed_r <= div_signed;
      ent_a_r      <= dividend;
      ent_b_r      <= divisor;
      ent_q_r      <= div_quotient;
      ent_r_r      <= div_remainder;
    end
  end

  // Look the request up in the stored entry
  always_comb begin
    hit_s = ent_valid_r && (ent_a_r == req_a) && (ent_b_r == req_b) &&
            (ent_signed_r == req_signed_s);
    if (req_rem_s) begin
      hit_data_s = ent_r_r;
    end else begin
      hit_data_s = ent_q_r;
    end
  end
`else
  // Without reuse every ordinary request is sent to the divider
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = ZERO;
  end
`endif

  // Kill strobe to the divider in the flush cycle itself; reset resets the divider directly
  always_comb begin
    if (!reset && flush && ((state_r == ISSUE) || (state_r == WAIT))) begin
      div_flush = 1'b1;
    end else begin
      div_flush = 1'b0;
    end
  end

  // Control FSM with registered handshake and divider outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      select_rem_r <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= ZERO;
      div_valid    <= 1'b0;
      div_signed   <= 1'b0;
      dividend     <= ZERO;
      divisor      <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && !flush) begin
            select_rem_r <= req_rem_s;
            req_ready    <= 1'b0;
            if (special_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= special_data_s;
            end else if (hit_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= hit_data_s;
            end else begin
              state_r    <= ISSUE;
              div_valid  <= 1'b1;
              div_signed <= req_signed_s;
              dividend   <= req_a;
              divisor    <= req_b;
            end
          end
        end
        ISSUE: begin
          if (flush) begin
            state_r   <= IDLE;
            div_valid <= 1'b0;
            req_ready <= 1'b1;
          end else if (div_ready) begin
            state_r   <= WAIT;
            div_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (flush) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
          end else if (div_out_valid) begin
            state_r    <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= select_rem_r ? div_remainder : div_quotient;
          end
        end
        RESP: begin
          // A flush retires the response without waiting for resp_ready
          if (flush || resp_ready) begin
            state_r    <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          div_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_div_ctrl.sv
// Directed bench for ysyx_23060077_div_ctrl: behavioural divider stub, transaction-level
// RV32M result model with a per-cycle compare process, and hand-computed literal checks.
module tb_ysyx_23060077_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, flush;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        div_valid, div_ready, div_signed, div_flush, div_out_valid;
  logic [31:0] dividend, divisor, div_quotient, div_remainder;

  int vectors = 0;
  int miscompares = 0;
  int issue_count = 0;
  int div_lat = 3;
  int ready_stall = 0;

  logic        m_busy = 1'b0;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_data = 32'd0;

  ysyx_23060077_div_ctrl #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .div_flush(div_flush),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clock = ~clock;

  // RV32M result for op 00 DIV, 01 DIVU, 10 REM, 11 REMU
  function automatic logic [31:0] rv_model(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    if (!op[0]) return op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return op[1] ? a % b : a / b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Divider stub: accepts on div_valid&&div_ready, answers after div_lat cycles
  initial begin
    logic        fl, hs, sg, busy;
    logic [31:0] dvd, dvs;
    int          cnt;
    div_out_valid = 1'b0; div_quotient = 32'd0; div_remainder = 32'd0;
    div_ready = 1'b1; busy = 1'b0; cnt = 0;
    forever begin
      @(posedge clock);
      fl = div_flush || reset; hs = div_valid && div_ready;
      dvd = dividend; dvs = divisor; sg = div_signed;
      #1;
      div_out_valid = 1'b0;
      if (ready_stall > 0) begin
        ready_stall--;
        div_ready = (ready_stall == 0);
      end
      if (fl) busy = 1'b0;
      else if (hs) begin
        busy = 1'b1; cnt = div_lat; issue_count++;
        div_quotient  = rv_model({1'b0, ~sg}, dvd, dvs);
        div_remainder = rv_model({1'b1, ~sg}, dvd, dvs);
      end else if (busy && cnt > 0) cnt--;
      if (busy && cnt == 0) begin
        div_out_valid = 1'b1; busy = 1'b0;
      end
    end
  end

  // Transaction model: one outstanding operation, result from rv_model
  initial forever begin
    @(posedge clock);
    if (reset) m_busy = 1'b0;
    else if (!m_busy) begin
      if (req_valid && !flush) begin
        m_busy = 1'b1; m_op = req_op; m_a = req_a; m_b = req_b;
        m_data = rv_model(req_op, req_a, req_b);
      end
    end else if (flush || (resp_valid && resp_ready)) m_busy = 1'b0;
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, ~m_busy});
      if (resp_valid) begin
        chk("resp_owner", {31'd0, m_busy}, 32'd1);
        chk("resp_data", resp_data, m_data);
      end
      if (div_valid) begin
        chk("div_dividend", dividend, m_a);
        chk("div_divisor", divisor, m_b);
        chk("div_signed", {31'd0, div_signed}, {31'd0, ~m_op[0]});
      end
    end
  end

  task automatic check_reset_values(input string name);
    chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({name, "_resp_data"}, resp_data, 32'd0);
    chk({name, "_div_valid"}, {31'd0, div_valid}, 32'd0);
    chk({name, "_div_flush"}, {31'd0, div_flush}, 32'd0);
    chk({name, "_div_signed"}, {31'd0, div_signed}, 32'd0);
    chk({name, "_dividend"}, dividend, 32'd0);
    chk({name, "_divisor"}, divisor, 32'd0);
  endtask

  // One full transaction; exp_lat 0 means "one cycle after div_out_valid"
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_issues, input int exp_lat,
                        input int hold, input string name);
    int ic0, n, dov_n;
    bit seen;
    ic0 = issue_count; dov_n = -100; seen = 1'b0; n = 0;
    chk({name, "_ready_before"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clock); #1;
    req_valid = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clock);
      n++;
      if (resp_valid) seen = 1'b1;
      else if (div_out_valid) dov_n = n;
    end
    chk({name, "_resp_seen"}, {31'd0, seen}, 32'd1);
    if (exp_lat > 0) chk({name, "_latency"}, n, exp_lat);
    else chk({name, "_latency"}, n, dov_n + 1);
    chk({name, "_data"}, resp_data, exp);
    chk({name, "_issues"}, issue_count - ic0, exp_issues);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({name, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({name, "_hold_data"}, resp_data, exp);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    @(negedge clock);
    chk({name, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({name, "_done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic start_and_reach_wait(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input string name);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk({name, "_issue_div_valid"}, {31'd0, div_valid}, 32'd1);
    @(negedge clock);
    chk({name, "_wait_div_valid"}, {31'd0, div_valid}, 32'd0);
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (resp_valid) hits++;
    end
    chk({name, "_no_resp"}, hits, 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_a = 32'd0; req_b = 32'd0; resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 0, 5, "div_m7_2");
    run_op(2'b11, 32'd7, 32'd0, 32'd7, 0, 1, 0, "remu_7_0");
    run_op(2'b01, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 1, 0, "divu_7_0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 0, "rem_ovf");

    // Flush while waiting on the divider
    start_and_reach_wait(2'b01, 32'd100, 32'd7, "flush_wait");
    flush = 1'b1; #1;
    chk("flush_wait_div_flush", {31'd0, div_flush}, 32'd1);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_wait_div_flush_drop", {31'd0, div_flush}, 32'd0);
    chk("flush_wait_req_ready", {31'd0, req_ready}, 32'd1);
    expect_quiet(6, "flush_wait");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 1, 0, 0, "remu_100_7");

    // Flush together with a request in IDLE: nothing is accepted
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd9; req_b = 32'd3; flush = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("flush_idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_idle_div_valid", {31'd0, div_valid}, 32'd0);
    req_valid = 1'b0; flush = 1'b0;
    expect_quiet(3, "flush_idle");

    // Flush in RESP retires the response without resp_ready
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd5; req_b = 32'd0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("flush_resp_valid_before", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_resp_valid_after", {31'd0, resp_valid}, 32'd0);
    chk("flush_resp_req_ready", {31'd0, req_ready}, 32'd1);

    div_lat = 0;
    run_op(2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1, 0, 0, "divu_max_3");
    div_lat = 3; ready_stall = 3;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 1, 0, 0, "rem_m7_3_stall");
    div_lat = 5;
    run_op(2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1, 0, 0, "div_20_m3");
    div_lat = 3;

    // Reset while waiting, with flush also high: reset wins and no kill strobe
    start_and_reach_wait(2'b00, 32'd9, 32'd3, "reset_wait");
    reset = 1'b1; flush = 1'b1; #1;
    chk("reset_wait_div_flush", {31'd0, div_flush}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check_reset_values("reset_wait");
    reset = 1'b0; flush = 1'b0;
    expect_quiet(6, "reset_wait");

    run_op(2'b00, 32'd100, 32'd7, 32'd14, 1, 0, 0, "div_100_7");
`ifdef YSYX_23060077_DIV_REUSE_EN
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 0, 1, 0, "rem_100_7_reuse");
`else
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 1, 0, 0, "rem_100_7_issue");
`endif

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
